// File: rtl/veda_lsu_pkg.sv
// Shared types and constants for the VEDA load/store unit.
package veda_lsu_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned OFF_W      = 16;
  localparam int unsigned TAG_W      = 5;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/veda_lsu_if.sv
// Request/response and data-memory bundle for the VEDA load/store unit.
// master: execute/writeback/memory environment; slave: the LSU.
interface veda_lsu_if
  import veda_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [XLEN-1:0]   req_base;
  logic [OFF_W-1:0]  req_offset;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_rd;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_rd;
  logic              resp_store;
  logic              resp_err;

  logic              mem_w_en;
  logic              mem_mode;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_datain;
  logic [DATA_W-1:0] mem_dataout;

  modport master (
    output req_valid, req_store, req_base, req_offset, req_wdata, req_rd,
    output resp_ready, mem_dataout,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_store, resp_err,
    input  mem_w_en, mem_mode, mem_address, mem_datain
  );

  modport slave (
    input  req_valid, req_store, req_base, req_offset, req_wdata, req_rd,
    input  resp_ready, mem_dataout,
    output req_ready, resp_valid, resp_data, resp_rd, resp_store, resp_err,
    output mem_w_en, mem_mode, mem_address, mem_datain
  );

endinterface

// File: rtl/veda_lsu_agen.sv
// Address generation: base + sign-extended offset (mod 2^32), truncated
// word address and an out-of-range flag for addresses beyond the memory.
module veda_lsu_agen
  import veda_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [XLEN-1:0]   base,
  input  logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] addr_c,
  output logic              oor_c
);

  logic [XLEN-1:0] eff;

  // Effective address and range flag.
  always_comb begin
    eff    = base + {{(XLEN-OFF_W){offset[OFF_W-1]}}, offset};
    addr_c = eff[ADDR_W-1:0];
    oor_c  = |eff[XLEN-1:ADDR_W];
  end

endmodule

// File: rtl/veda_lsu.sv
// VEDA load/store unit: accepts one load/store, issues a single memory
// access, returns data or a store acknowledge over a valid/ready response.
// Optional feature macro: VEDA_LSU_BOUNDS_CHECK_EN (flag addresses outside
// the memory with resp_err instead of truncating them).
module veda_lsu
  import veda_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  veda_lsu_if.slave     bus
);

  localparam int unsigned CNT_W = $clog2(READ_LAT + 1);

`ifdef VEDA_LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_c;
  logic              oor_c;
  logic              bad_c;

  veda_lsu_agen #(.ADDR_W(ADDR_W)) u_agen (
    .base   (bus.req_base),
    .offset (bus.req_offset),
    .addr_c (addr_c),
    .oor_c  (oor_c)
  );

  assign bad_c         = BOUNDS_EN && oor_c;
  assign bus.req_ready = (state == IDLE) && !rst;

  // Control FSM with registered memory and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.mem_w_en    <= 1'b0;
      bus.mem_mode    <= MODE_READ;
      bus.mem_address <= '0;
      bus.mem_datain  <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_data   <= '0;
      bus.resp_rd     <= '0;
      bus.resp_store  <= 1'b0;
      bus.resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.resp_rd    <= bus.req_rd;
            bus.resp_store <= bus.req_store;
            bus.resp_data  <= '0;
            bus.resp_err   <= bad_c;
            if (bad_c) begin
              // Out-of-range: skip the memory access entirely.
              state          <= RESP;
              bus.resp_valid <= 1'b1;
            end else begin
              state           <= ISSUE;
              bus.mem_w_en    <= 1'b1;
              bus.mem_mode    <= bus.req_store ? MODE_WRITE : MODE_READ;
              bus.mem_address <= addr_c;
              bus.mem_datain  <= bus.req_wdata;
            end
          end
        end
        ISSUE: begin
          bus.mem_w_en <= 1'b0;
          if (bus.resp_store) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= CNT_W'(READ_LAT);
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= bus.mem_dataout;
          end
          cnt <= cnt - CNT_W'(1);
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_veda_lsu.sv
// Directed self-checking bench for veda_lsu: one instance with READ_LAT=1
// and one with READ_LAT=3, each backed by a small latency-accurate memory.
module tb_veda_lsu;
  import veda_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tot  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  veda_lsu_if a_if ();
  veda_lsu_if b_if ();

  veda_lsu #(.READ_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  veda_lsu #(.READ_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  // Memory A: one-cycle read latency; poison value when no read data is due.
  logic [31:0] mem_a [512];
  logic        va;
  logic [31:0] da;
  always @(posedge clk) begin
    if (rst) va <= 1'b0;
    else begin
      if (a_if.mem_w_en && a_if.mem_mode) mem_a[a_if.mem_address] <= a_if.mem_datain;
      va <= a_if.mem_w_en && !a_if.mem_mode;
      da <= mem_a[a_if.mem_address];
    end
  end
  assign a_if.mem_dataout = va ? da : 32'hDEAD_BEEF;

  // Memory B: three-cycle read latency.
  logic [31:0] mem_b [512];
  logic [2:0]  vb;
  logic [31:0] db0, db1, db2;
  always @(posedge clk) begin
    if (rst) vb <= 3'b000;
    else begin
      if (b_if.mem_w_en && b_if.mem_mode) mem_b[b_if.mem_address] <= b_if.mem_datain;
      vb  <= {vb[1:0], b_if.mem_w_en && !b_if.mem_mode};
      db0 <= mem_b[b_if.mem_address];
      db1 <= db0;
      db2 <= db1;
    end
  end
  assign b_if.mem_dataout = vb[2] ? db2 : 32'hDEAD_BEEF;

  // Count memory enable pulses on instance A.
  int wen_cnt_a = 0;
  always @(posedge clk) if (a_if.mem_w_en) wen_cnt_a <= wen_cnt_a + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic req_a(input logic st, input logic [31:0] base, input logic [15:0] off,
                       input logic [31:0] wd, input logic [4:0] rd);
    a_if.req_valid  = 1'b1;
    a_if.req_store  = st;
    a_if.req_base   = base;
    a_if.req_offset = off;
    a_if.req_wdata  = wd;
    a_if.req_rd     = rd;
  endtask

  task automatic req_b(input logic st, input logic [31:0] base, input logic [31:0] wd,
                       input logic [4:0] rd);
    b_if.req_valid  = 1'b1;
    b_if.req_store  = st;
    b_if.req_base   = base;
    b_if.req_offset = 16'h0000;
    b_if.req_wdata  = wd;
    b_if.req_rd     = rd;
  endtask

  int wen_snap;
  bit seen_resp;

  initial begin
    a_if.req_valid = 1'b0; a_if.req_store = 1'b0; a_if.req_base = '0;
    a_if.req_offset = '0; a_if.req_wdata = '0; a_if.req_rd = '0; a_if.resp_ready = 1'b1;
    b_if.req_valid = 1'b0; b_if.req_store = 1'b0; b_if.req_base = '0;
    b_if.req_offset = '0; b_if.req_wdata = '0; b_if.req_rd = '0; b_if.resp_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_req_ready", a_if.req_ready, 0);
    chk("rst_resp_valid", a_if.resp_valid, 0);
    chk("rst_mem_w_en", a_if.mem_w_en, 0);
    chk("rst_mem_address", a_if.mem_address, 0);
    chk("rst_resp_data", a_if.resp_data, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", a_if.req_ready, 1);

    // Store 9 to word 5
    req_a(1'b1, 32'd5, 16'h0000, 32'd9, 5'd2);
    tick();
    a_if.req_valid = 1'b0;
    chk("st_w_en", a_if.mem_w_en, 1);
    chk("st_mode", a_if.mem_mode, 1);
    chk("st_addr", a_if.mem_address, 5);
    chk("st_datain", a_if.mem_datain, 9);
    chk("st_req_ready_busy", a_if.req_ready, 0);
    chk("st_resp_early", a_if.resp_valid, 0);
    tick();
    chk("st_w_en_drop", a_if.mem_w_en, 0);
    chk("st_resp_valid", a_if.resp_valid, 1);
    chk("st_resp_store", a_if.resp_store, 1);
    chk("st_resp_data", a_if.resp_data, 0);
    chk("st_resp_err", a_if.resp_err, 0);
    tick();
    chk("st_done", a_if.resp_valid, 0);
    chk("st_idle_ready", a_if.req_ready, 1);

    // Load word 5 into rd 3
    req_a(1'b0, 32'd5, 16'h0000, 32'd0, 5'd3);
    tick();
    a_if.req_valid = 1'b0;
    chk("ld_w_en", a_if.mem_w_en, 1);
    chk("ld_mode", a_if.mem_mode, 0);
    chk("ld_addr", a_if.mem_address, 5);
    tick();
    chk("ld_wait_no_resp", a_if.resp_valid, 0);
    tick();
    chk("ld_resp_valid", a_if.resp_valid, 1);
    chk("ld_resp_data", a_if.resp_data, 9);
    chk("ld_resp_rd", a_if.resp_rd, 3);
    chk("ld_resp_store", a_if.resp_store, 0);
    tick();
    chk("ld_done", a_if.resp_valid, 0);

    // Negative offset: 10 + (-9) = 1
    req_a(1'b1, 32'd10, 16'hFFF7, 32'h55, 5'd0);
    tick();
    a_if.req_valid = 1'b0;
    chk("neg_addr", a_if.mem_address, 1);
    chk("neg_w_en", a_if.mem_w_en, 1);
    tick();
    tick();

    // Backpressure on a load of word 1, next request waiting behind it
    a_if.resp_ready = 1'b0;
    req_a(1'b0, 32'd1, 16'h0000, 32'd0, 5'd7);
    tick();
    req_a(1'b1, 32'd7, 16'h0000, 32'h77, 5'd4);
    tick();
    tick();
    chk("bp_resp_valid", a_if.resp_valid, 1);
    chk("bp_resp_data", a_if.resp_data, 32'h55);
    chk("bp_resp_rd", a_if.resp_rd, 7);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", i), a_if.resp_valid, 1);
      chk($sformatf("bp_hold_data%0d", i), a_if.resp_data, 32'h55);
      chk($sformatf("bp_hold_ready%0d", i), a_if.req_ready, 0);
      chk($sformatf("bp_hold_wen%0d", i), a_if.mem_w_en, 0);
    end
    a_if.resp_ready = 1'b1;
    tick();
    chk("bp_hs_valid", a_if.resp_valid, 0);
    chk("bp_hs_no_accept", a_if.mem_w_en, 0);
    chk("bp_hs_ready", a_if.req_ready, 1);
    tick();
    a_if.req_valid = 1'b0;
    chk("bp_next_w_en", a_if.mem_w_en, 1);
    chk("bp_next_mode", a_if.mem_mode, 1);
    chk("bp_next_addr", a_if.mem_address, 7);
    tick();
    chk("bp_next_resp", a_if.resp_valid, 1);
    tick();

    // Reset during WAIT
    req_a(1'b0, 32'd5, 16'h0000, 32'd0, 5'd1);
    tick();
    a_if.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", a_if.resp_valid, 0);
    chk("mid_rst_w_en", a_if.mem_w_en, 0);
    chk("mid_rst_data", a_if.resp_data, 0);
    chk("mid_rst_addr", a_if.mem_address, 0);
    chk("mid_rst_ready", a_if.req_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_after", a_if.req_ready, 1);
    seen_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_if.resp_valid) seen_resp = 1'b1;
    end
    chk("mid_rst_no_resp", seen_resp, 0);
    req_a(1'b1, 32'd7, 16'h0000, 32'h1234, 5'd6);
    tick();
    a_if.req_valid = 1'b0;
    chk("fresh_w_en", a_if.mem_w_en, 1);
    chk("fresh_addr", a_if.mem_address, 7);
    chk("fresh_datain", a_if.mem_datain, 32'h1234);
    tick();
    chk("fresh_resp", a_if.resp_valid, 1);
    chk("fresh_resp_rd", a_if.resp_rd, 6);
    tick();

    // Out-of-range address 0x200
    wen_snap = wen_cnt_a;
    req_a(1'b1, 32'h200, 16'h0000, 32'h42, 5'd9);
    tick();
    a_if.req_valid = 1'b0;
`ifdef VEDA_LSU_BOUNDS_CHECK_EN
    chk("oob_w_en", a_if.mem_w_en, 0);
    chk("oob_resp_valid", a_if.resp_valid, 1);
    chk("oob_resp_err", a_if.resp_err, 1);
    chk("oob_resp_data", a_if.resp_data, 0);
    tick();
    chk("oob_done", a_if.resp_valid, 0);
    chk("oob_no_access", wen_cnt_a, wen_snap);
`else
    chk("trunc_w_en", a_if.mem_w_en, 1);
    chk("trunc_addr", a_if.mem_address, 0);
    tick();
    chk("trunc_resp_valid", a_if.resp_valid, 1);
    chk("trunc_resp_err", a_if.resp_err, 0);
    chk("trunc_access", wen_cnt_a, wen_snap + 1);
    tick();
`endif

    // READ_LAT=3 instance: store then load word 12
    req_b(1'b1, 32'd12, 32'hCAFE, 5'd0);
    tick();
    b_if.req_valid = 1'b0;
    chk("l3_st_addr", b_if.mem_address, 12);
    tick();
    chk("l3_st_resp", b_if.resp_valid, 1);
    tick();
    req_b(1'b0, 32'd12, 32'd0, 5'd11);
    tick();
    b_if.req_valid = 1'b0;
    chk("l3_ld_w_en", b_if.mem_w_en, 1);
    tick();
    tick();
    tick();
    chk("l3_ld_not_yet", b_if.resp_valid, 0);
    tick();
    chk("l3_ld_resp_valid", b_if.resp_valid, 1);
    chk("l3_ld_resp_data", b_if.resp_data, 32'hCAFE);
    chk("l3_ld_resp_rd", b_if.resp_rd, 11);
    tick();
    chk("l3_ld_done", b_if.resp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
